// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type and default constants for the uart receive path
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 16;
  localparam int DEFAULT_DATA_BITS    = 8;
  localparam int DEFAULT_SYNC_STAGES  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - per-bit cycle counter with half-bit and full-bit terminal strobes
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic half_tc,
  output logic full_tc
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cyc;

  // Saturates at the full-bit count; the receiver clears it whenever a strobe is consumed.
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      cyc <= '0;
    end else if (cyc != FULL_LAST) begin
      cyc <= cyc + 1'b1;
    end
  end

  assign half_tc = (cyc == HALF_LAST);
  assign full_tc = (cyc == FULL_LAST);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 uart receiver with mid-bit sampling and a one-entry valid/ready holding register
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int SYNC_STAGES  = DEFAULT_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Rx,
  output logic [DATA_BITS-1:0] databus_write,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  uart_rx_state_t       state;
  logic [SYNC_STAGES-1:0] sync;
  logic                 rxs;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 half_tc;
  logic                 full_tc;
  logic                 timer_clear;

  assign rxs = sync[SYNC_STAGES-1];

  // Timer restarts on entry to every bit window and is held at zero while waiting for the line.
  assign timer_clear = (state == IDLE) || (state == BREAK) ||
                       ((state == START) && half_tc) || full_tc;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .half_tc(half_tc),
    .full_tc(full_tc)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], Rx};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      shift         <= '0;
      databus_write <= '0;
      rx_valid      <= 1'b0;
      frame_err     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (!rxs) state <= START;
        end
        START: begin
          if (half_tc) begin
            if (!rxs) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (full_tc) begin
            shift[bit_cnt] <= rxs;
            if (bit_cnt == LAST_BIT) begin
              state <= STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (full_tc) begin
            if (rxs) begin
              state <= IDLE;
              // A same-cycle accept frees the register, so the new byte lands without a bubble.
              if (!rx_valid || rx_ready) begin
                databus_write <= shift;
                rx_valid      <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end
        end
        BREAK: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx: vector table, corner sequences, random frames
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int DB  = 8;
  localparam int SS  = 2;
  localparam int LAT = CPB / 2 + (DB + 1) * CPB + 1 + SS;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       Rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] databus_write;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  uart_rx #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB),
    .SYNC_STAGES (SS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .Rx           (Rx),
    .databus_write(databus_write),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .frame_err    (frame_err),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int unsigned cnt = 0;
  always @(posedge clk) cnt <= cnt + 1;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  got_q[$];
  int unsigned rise_q[$];
  int          ferr_cnt = 0;
  int          ovr_cnt = 0;
  int          vcyc = 0;
  logic        prev_valid = 1'b0;

  always @(negedge clk) begin
    if (rx_valid && !prev_valid) rise_q.push_back(cnt);
    prev_valid = rx_valid;
    if (rx_valid) vcyc++;
    if (rx_valid && rx_ready) got_q.push_back(databus_write);
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_bytes;
    int         exp_ferr;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    rise_q.delete();
    ferr_cnt = 0;
    ovr_cnt = 0;
    vcyc = 0;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    Rx = b;
    wait_clks(CPB);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, output int unsigned t0);
    t0 = cnt;
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  logic [7:0]  exp_q[$];
  int unsigned exp_rise[$];

  initial begin
    int unsigned t0;
    int unsigned t1;
    int          nbad;
    logic [7:0]  d;
    logic        bad;
    int          gap;

    tbl[0] = '{8'hA5, 1'b1, 1, 0};
    tbl[1] = '{8'h00, 1'b1, 1, 0};
    tbl[2] = '{8'hFF, 1'b1, 1, 0};
    tbl[3] = '{8'h3C, 1'b0, 0, 1};
    tbl[4] = '{8'h81, 1'b1, 1, 0};
    tbl[5] = '{8'h01, 1'b0, 0, 1};

    reset = 1'b0;
    Rx = 1'b1;
    rx_ready = 1'b1;
    wait_clks(4);
    check("reset databus_write", databus_write, 0);
    check("reset rx_valid", rx_valid, 0);
    check("reset frame_err", frame_err, 0);
    check("reset overrun", overrun, 0);
    reset = 1'b1;
    wait_clks(2 * CPB);

    for (int v = 0; v < 6; v++) begin
      clear_mon();
      send_frame(tbl[v].data, tbl[v].stop, t0);
      send_bit(1'b1);
      send_bit(1'b1);
      check($sformatf("tbl%0d bytes", v), got_q.size(), tbl[v].exp_bytes);
      check($sformatf("tbl%0d valid cycles", v), vcyc, tbl[v].exp_bytes);
      check($sformatf("tbl%0d frame_err", v), ferr_cnt, tbl[v].exp_ferr);
      check($sformatf("tbl%0d overrun", v), ovr_cnt, 0);
      if (tbl[v].exp_bytes == 1 && got_q.size() == 1)
        check($sformatf("tbl%0d data", v), got_q[0], tbl[v].data);
      if (tbl[v].exp_bytes == 1 && rise_q.size() == 1)
        check($sformatf("tbl%0d latency", v), rise_q[0] - t0, LAT);
    end

    // Short low glitch must be rejected at the half-bit check.
    clear_mon();
    Rx = 1'b0;
    wait_clks(5);
    Rx = 1'b1;
    wait_clks(12 * CPB);
    check("glitch valid", vcyc, 0);
    check("glitch frame_err", ferr_cnt, 0);

    // Bad stop bit followed by a held-low line, then a clean frame.
    clear_mon();
    send_frame(8'h3C, 1'b0, t0);
    Rx = 1'b0;
    wait_clks(40);
    Rx = 1'b1;
    wait_clks(2 * CPB);
    check("break frame_err pulses", ferr_cnt, 1);
    check("break valid", vcyc, 0);
    clear_mon();
    send_frame(8'h81, 1'b1, t0);
    send_bit(1'b1);
    send_bit(1'b1);
    check("after break bytes", got_q.size(), 1);
    if (got_q.size() == 1) check("after break data", got_q[0], 8'h81);
    check("after break frame_err", ferr_cnt, 0);

    // Holding register full: second byte is dropped with one overrun pulse.
    clear_mon();
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, t0);
    send_bit(1'b1);
    send_frame(8'h22, 1'b1, t0);
    send_bit(1'b1);
    send_bit(1'b1);
    check("overrun pulses", ovr_cnt, 1);
    check("overrun rx_valid held", rx_valid, 1);
    check("overrun data kept", databus_write, 8'h11);
    rx_ready = 1'b1;
    wait_clks(3);
    check("overrun accepted count", got_q.size(), 1);
    if (got_q.size() == 1) check("overrun accepted data", got_q[0], 8'h11);
    check("overrun rx_valid cleared", rx_valid, 0);

    // Back-to-back frames with no idle bits.
    clear_mon();
    send_frame(8'h55, 1'b1, t0);
    send_frame(8'hAA, 1'b1, t1);
    send_bit(1'b1);
    send_bit(1'b1);
    check("b2b bytes", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("b2b first", got_q[0], 8'h55);
      check("b2b second", got_q[1], 8'hAA);
    end
    check("b2b rises", rise_q.size(), 2);
    if (rise_q.size() == 2) check("b2b spacing", rise_q[1] - rise_q[0], 10 * CPB);

    // Reset in the middle of a frame.
    clear_mon();
    Rx = 1'b0;
    wait_clks(5 * CPB);
    reset = 1'b0;
    Rx = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_clks(1);
      check($sformatf("midreset outputs c%0d", i), {databus_write, rx_valid, frame_err, overrun}, 0);
    end
    reset = 1'b1;
    wait_clks(2 * CPB);
    check("midreset no output", got_q.size() + ferr_cnt, 0);
    clear_mon();
    send_frame(8'h7E, 1'b1, t0);
    send_bit(1'b1);
    send_bit(1'b1);
    check("post reset bytes", got_q.size(), 1);
    if (got_q.size() == 1) check("post reset data", got_q[0], 8'h7E);
    check("post reset frame_err", ferr_cnt, 0);

    // Random frames against a frame-level model: good frames deliver their byte LAT clocks after the start edge.
    clear_mon();
    exp_q.delete();
    exp_rise.delete();
    nbad = 0;
    for (int f = 0; f < 40; f++) begin
      d   = 8'($urandom);
      bad = ($urandom_range(0, 5) == 0);
      gap = bad ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 2));
      send_frame(d, !bad, t0);
      if (bad) begin
        nbad++;
      end else begin
        exp_q.push_back(d);
        exp_rise.push_back(t0 + LAT);
      end
      repeat (gap) send_bit(1'b1);
    end
    send_bit(1'b1);
    send_bit(1'b1);
    check("rand byte count", got_q.size(), exp_q.size());
    check("rand rise count", rise_q.size(), exp_rise.size());
    check("rand frame_err count", ferr_cnt, nbad);
    check("rand overrun count", ovr_cnt, 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check($sformatf("rand data %0d", i), got_q[i], exp_q[i]);
      if (i < rise_q.size()) check($sformatf("rand latency %0d", i), rise_q[i], exp_rise[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
